// File: rtl/mem_bus_arbiter.sv
// Data-memory port arbiter between the Icache and Dcache controllers, with load-tag owner routing.
// Optional Icache aging guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  Icache2arb_command,
  input  logic [63:0] Icache2arb_addr,
  input  logic [1:0]  Dcache2arb_command,
  input  logic [63:0] Dcache2arb_addr,
  input  logic [63:0] Dcache2arb_data,
  input  logic [3:0]  Dmem2arb_response,
  input  logic [3:0]  Dmem2arb_tag,
  input  logic [63:0] Dmem2arb_data,
  output logic [1:0]  arb2Dmem_command,
  output logic [63:0] arb2Dmem_addr,
  output logic [63:0] arb2Dmem_data,
  output logic [3:0]  arb2Icache_response,
  output logic [3:0]  arb2Dcache_response,
  output logic [3:0]  arb2Icache_tag,
  output logic [3:0]  arb2Dcache_tag,
  output logic [63:0] arb2Icache_data,
  output logic [63:0] arb2Dcache_data,
  output logic [4:0]  outstanding_cnt,
  output logic        arb_tag_err
);

  localparam logic [1:0] BusNone = 2'd0;
  localparam logic [1:0] BusLoad = 2'd1;

  // Bit 0 of the owner table is never set: tag 0 means "none".
  logic [15:0] valid_q, valid_d;
  logic [15:0] owner_q, owner_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        i_req, d_req, promote, grant_i, grant_d, load_acc;

  assign i_req = (Icache2arb_command != BusNone);
  assign d_req = (Dcache2arb_command != BusNone);

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);
  logic [3:0] starve_q, starve_d;

  assign promote = (starve_q == StarveLimit);

  always_comb begin
    starve_d = starve_q;
    if (!i_req || (arb2Icache_response != 4'd0)) begin
      starve_d = 4'd0;
    end else if (starve_q != StarveLimit) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = (STARVE_LIMIT != 0);
  assign promote      = 1'b0;
`endif

  // Grants are forced off while reset is held so every request-side output reads idle.
  assign grant_i  = reset && i_req && (!d_req || promote);
  assign grant_d  = reset && d_req && !grant_i;
  assign load_acc = (grant_i || grant_d) && (Dmem2arb_response != 4'd0) &&
                    (arb2Dmem_command == BusLoad);

  always_comb begin
    arb2Dmem_command    = BusNone;
    arb2Dmem_addr       = 64'd0;
    arb2Dmem_data       = 64'd0;
    arb2Icache_response = 4'd0;
    arb2Dcache_response = 4'd0;
    if (grant_i) begin
      arb2Dmem_command    = Icache2arb_command;
      arb2Dmem_addr       = Icache2arb_addr;
      arb2Icache_response = Dmem2arb_response;
    end else if (grant_d) begin
      arb2Dmem_command    = Dcache2arb_command;
      arb2Dmem_addr       = Dcache2arb_addr;
      arb2Dmem_data       = Dcache2arb_data;
      arb2Dcache_response = Dmem2arb_response;
    end
  end

  always_comb begin
    arb2Icache_tag  = 4'd0;
    arb2Dcache_tag  = 4'd0;
    arb2Icache_data = reset ? Dmem2arb_data : 64'd0;
    arb2Dcache_data = reset ? Dmem2arb_data : 64'd0;
    if (reset && (Dmem2arb_tag != 4'd0) && valid_q[Dmem2arb_tag]) begin
      if (owner_q[Dmem2arb_tag]) begin
        arb2Dcache_tag = Dmem2arb_tag;
      end else begin
        arb2Icache_tag = Dmem2arb_tag;
      end
    end
  end

  // Clear on completion first so a same-tag accept in the same cycle overrides it.
  always_comb begin
    valid_d = valid_q;
    owner_d = owner_q;
    err_d   = err_q;
    if (Dmem2arb_tag != 4'd0) begin
      if (valid_q[Dmem2arb_tag]) begin
        valid_d[Dmem2arb_tag] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (load_acc) begin
      valid_d[Dmem2arb_response] = 1'b1;
      owner_d[Dmem2arb_response] = grant_d;
    end
    cnt_d = 5'($countones(valid_d));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 16'd0;
      owner_q <= 16'd0;
      cnt_q   <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign outstanding_cnt = cnt_q;
  assign arb_tag_err     = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios then randomized traffic vs a tag-map model.
module tb_mem_bus_arbiter;

  localparam logic [1:0] BN = 2'd0;
  localparam logic [1:0] BL = 2'd1;
  localparam logic [1:0] BS = 2'd2;
  localparam int Limit = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clock, reset;
  logic [1:0]  i_cmd, d_cmd, m_cmd;
  logic [63:0] i_addr, d_addr, d_data, mem_data, m_addr, m_data, i_rdata, d_rdata;
  logic [3:0]  mem_resp, mem_tag, i_resp, d_resp, i_tag, d_tag;
  logic [4:0]  cnt;
  logic        err;

  mem_bus_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .clock(clock), .reset(reset),
    .Icache2arb_command(i_cmd), .Icache2arb_addr(i_addr),
    .Dcache2arb_command(d_cmd), .Dcache2arb_addr(d_addr), .Dcache2arb_data(d_data),
    .Dmem2arb_response(mem_resp), .Dmem2arb_tag(mem_tag), .Dmem2arb_data(mem_data),
    .arb2Dmem_command(m_cmd), .arb2Dmem_addr(m_addr), .arb2Dmem_data(m_data),
    .arb2Icache_response(i_resp), .arb2Dcache_response(d_resp),
    .arb2Icache_tag(i_tag), .arb2Dcache_tag(d_tag),
    .arb2Icache_data(i_rdata), .arb2Dcache_data(d_rdata),
    .outstanding_cnt(cnt), .arb_tag_err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit          rst_n;
    logic [1:0]  cmd;
    logic [63:0] addr, data, idata, ddata;
    logic [3:0]  iresp, dresp, itag, dtag;
    logic [4:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  // Model: owner of each tag (-1 free, 0 Icache, 1 Dcache), sticky error, starvation age.
  int m_owner[16];
  int m_starve;
  bit m_err;
  logic [3:0] last_iresp, last_dresp;

  function automatic int m_count();
    int n = 0;
    for (int t = 1; t < 16; t++) if (m_owner[t] >= 0) n++;
    return n;
  endfunction

  task automatic m_reset();
    for (int t = 0; t < 16; t++) m_owner[t] = -1;
    m_starve = 0;
    m_err    = 1'b0;
  endtask

  function automatic bit m_grant_i(bit ir, bit dr);
    return ir && (!dr || (Guard && (m_starve == Limit)));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
    end
  endtask

  // Drive one cycle, push the expected outputs, advance the model to the next cycle.
  task automatic cycle(input bit rn, input logic [1:0] ic, input logic [63:0] ia,
                       input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] md);
    exp_t e;
    bit ir, dr, gi, gd;
    reset = rn; i_cmd = ic; i_addr = ia; d_cmd = dc; d_addr = da; d_data = dd;
    mem_resp = rsp; mem_tag = tg; mem_data = md;
    ir = (ic != BN);
    dr = (dc != BN);
    gi = rn && m_grant_i(ir, dr);
    gd = rn && dr && !gi;
    e.rst_n = rn;
    e.cnt   = 5'(m_count());
    e.err   = m_err;
    e.cmd   = gi ? ic : (gd ? dc : BN);
    e.addr  = gi ? ia : (gd ? da : 64'd0);
    e.data  = gd ? dd : 64'd0;
    e.iresp = gi ? rsp : 4'd0;
    e.dresp = gd ? rsp : 4'd0;
    e.idata = rn ? md : 64'd0;
    e.ddata = rn ? md : 64'd0;
    e.itag  = 4'd0;
    e.dtag  = 4'd0;
    if (rn && tg != 4'd0 && m_owner[tg] >= 0) begin
      if (m_owner[tg] == 0) e.itag = tg;
      else e.dtag = tg;
    end
    exp_q.push_back(e);
    if (!rn) begin
      m_reset();
    end else begin
      if (tg != 4'd0) begin
        if (m_owner[tg] >= 0) m_owner[tg] = -1;
        else m_err = 1'b1;
      end
      if (rsp != 4'd0 && e.cmd == BL) m_owner[rsp] = gi ? 0 : 1;
      if (ir && e.iresp == 4'd0) m_starve = (m_starve < Limit) ? m_starve + 1 : Limit;
      else m_starve = 0;
    end
    last_iresp = e.iresp;
    last_dresp = e.dresp;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [3:0] tg, input logic [63:0] md);
    cycle(1'b1, BN, 64'd0, BN, 64'd0, 64'd0, 4'd0, tg, md);
  endtask

  // Monitor: compares every presented cycle at the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("mem_cmd", 64'(m_cmd), 64'(mon_e.cmd));
        chk("mem_addr", m_addr, mon_e.addr);
        chk("mem_data", m_data, mon_e.data);
        chk("icache_resp", 64'(i_resp), 64'(mon_e.iresp));
        chk("dcache_resp", 64'(d_resp), 64'(mon_e.dresp));
        chk("icache_tag", 64'(i_tag), 64'(mon_e.itag));
        chk("dcache_tag", 64'(d_tag), 64'(mon_e.dtag));
        chk("icache_data", i_rdata, mon_e.idata);
        chk("dcache_data", d_rdata, mon_e.ddata);
        if (mon_e.rst_n) begin
          chk("outstanding_cnt", 64'(cnt), 64'(mon_e.cnt));
          chk("tag_err", 64'(err), 64'(mon_e.err));
        end
      end
    end
  end

  initial begin
    bit pi, pd, rn;
    logic [1:0]  dcmd_h;
    logic [63:0] ia_h, da_h, dd_h;
    logic [3:0]  rsp, tg;
    int cand[$];
    int r, wait_cycles;

    m_reset();
    reset = 1'b0; i_cmd = BN; d_cmd = BN; i_addr = '0; d_addr = '0; d_data = '0;
    mem_resp = '0; mem_tag = '0; mem_data = '0;
    @(posedge clock);
    #1;
    cycle(1'b0, BN, 64'd0, BN, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    cycle(1'b0, BL, 64'h40, BL, 64'h80, 64'd1, 4'd2, 4'd3, 64'h77);

    // Icache-only load, tag 3 routed back to Icache.
    cycle(1'b1, BL, 64'h100, BN, 64'd0, 64'd0, 4'd3, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    idle(4'd3, 64'hAA);
    idle(4'd0, 64'd0);
    // Simultaneous requests: Dcache wins, Icache retries.
    cycle(1'b1, BL, 64'h108, BL, 64'h300, 64'd0, 4'd5, 4'd0, 64'd0);
    cycle(1'b1, BL, 64'h108, BN, 64'd0, 64'd0, 4'd6, 4'd0, 64'd0);
    idle(4'd5, 64'h1234);
    idle(4'd6, 64'h5678);
    // Store: no owner entry.
    cycle(1'b1, BN, 64'd0, BS, 64'h200, 64'h55, 4'd7, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    // Tag 9 completes to Icache while Dcache is accepted with tag 9.
    cycle(1'b1, BL, 64'h900, BN, 64'd0, 64'd0, 4'd9, 4'd0, 64'd0);
    cycle(1'b1, BN, 64'd0, BL, 64'h980, 64'd0, 4'd9, 4'd9, 64'h99);
    idle(4'd0, 64'd0);
    idle(4'd9, 64'h9999);
    // Continuous contention: aging promotes Icache when the guard is built in.
    for (int k = 0; k < 7; k++) cycle(1'b1, BL, 64'h400, BS, 64'h500, 64'h66, 4'd10, 4'd0, 64'd0);
    idle(4'd10, 64'hA0);
    // Two loads outstanding, reset, then a stale tag.
    cycle(1'b1, BL, 64'h600, BN, 64'd0, 64'd0, 4'd1, 4'd0, 64'd0);
    cycle(1'b1, BN, 64'd0, BL, 64'h700, 64'd0, 4'd2, 4'd0, 64'd0);
    idle(4'd0, 64'd0);
    cycle(1'b0, BN, 64'd0, BN, 64'd0, 64'd0, 4'd0, 4'd0, 64'd0);
    idle(4'd2, 64'h22);
    idle(4'd0, 64'd0);

    // Randomized traffic with request hold-until-accepted.
    pi = 1'b0;
    pd = 1'b0;
    dcmd_h = BN; ia_h = '0; da_h = '0; dd_h = '0;
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(99) != 0);
      if (!pi && $urandom_range(1) == 1) begin
        pi = 1'b1;
        ia_h = {32'($urandom), 29'($urandom), 3'b000};
      end
      if (!pd && $urandom_range(1) == 1) begin
        pd = 1'b1;
        dcmd_h = ($urandom_range(1) == 1) ? BL : BS;
        da_h = {32'($urandom), 32'($urandom)};
        dd_h = {32'($urandom), 32'($urandom)};
      end
      tg = 4'd0;
      r = $urandom_range(99);
      cand.delete();
      if (r < 40) begin
        for (int t = 1; t < 16; t++) if (m_owner[t] >= 0) cand.push_back(t);
      end else if (r < 43) begin
        for (int t = 1; t < 16; t++) if (m_owner[t] < 0) cand.push_back(t);
      end
      if (cand.size() != 0) tg = 4'(cand[$urandom_range(cand.size() - 1)]);
      rsp = 4'd0;
      if (rn && (pi || pd) && $urandom_range(3) != 0) begin
        if (tg != 4'd0 && $urandom_range(2) == 0) begin
          rsp = tg;
        end else begin
          cand.delete();
          for (int t = 1; t < 16; t++) if (m_owner[t] < 0 || t == int'(tg)) cand.push_back(t);
          if (cand.size() != 0) rsp = 4'(cand[$urandom_range(cand.size() - 1)]);
        end
      end
      cycle(rn, pi ? BL : BN, ia_h, pd ? dcmd_h : BN, da_h, dd_h, rsp, tg,
            {32'($urandom), 32'($urandom)});
      if (last_iresp != 4'd0) pi = 1'b0;
      if (last_dresp != 4'd0) pd = 1'b0;
    end

    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 10) begin
      @(posedge clock);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expected cycles left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single data-memory port between the Icache controller and the Dcache controller. Each cycle it grants the port to one requester and records which side owns each outstanding load tag. It then steers every returning tag and data beat to that owner. It sits between both cache controllers and mem, adds no latency on the request path and keeps the Dcache refill/writeback path from starving instruction fetch.

## Interface
- `STARVE_LIMIT`, 4: consecutive blocked Icache cycles before Icache gets priority (1..15).
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; sampled on posedge, state cleared when `reset==0`.
- `Icache2arb_command`  in  BUS_COMMAND  Icache request (BUS_NONE/BUS_LOAD only).
- `Icache2arb_addr`  in  64  Icache load address, 8-byte aligned.
- `Dcache2arb_command`  in  BUS_COMMAND  Dcache request (BUS_NONE/BUS_LOAD/BUS_STORE).
- `Dcache2arb_addr`  in  64  Dcache address (load miss or writeback address).
- `Dcache2arb_data`  in  64  store data.
- `Dmem2arb_response`  in  4  mem accept tag this cycle; 0 = rejected.
- `Dmem2arb_tag`  in  4  tag of a completing load; 0 = none.
- `Dmem2arb_data`  in  64  data for `Dmem2arb_tag`.
- `arb2Dmem_command`  out  BUS_COMMAND  granted command.
- `arb2Dmem_addr`  out  64  granted address.
- `arb2Dmem_data`  out  64  `Dcache2arb_data` when Dcache granted, else 0.
- `arb2Icache_response`, `arb2Dcache_response`  out  4 each  accept tag; 0 = retry next cycle.
- `arb2Icache_tag`, `arb2Dcache_tag`  out  4 each  completing tag routed to owner; 0 otherwise.
- `arb2Icache_data`, `arb2Dcache_data`  out  64 each  `Dmem2arb_data` (unqualified; valid when tag nonzero).
- `outstanding_cnt`  out  5  number of valid owner-table entries.
- `arb_tag_err`  out  1  sticky: a nonzero `Dmem2arb_tag` arrived with no valid owner.

## Operation
- Owner table: 15 entries indexed by tag 1..15, each {valid, owner (0=Icache, 1=Dcache)}.
- Grant, combinational:
  - Only one side requesting: that side is granted.
  - Both requesting: Dcache wins, unless the starvation guard is active and `starve_cnt == STARVE_LIMIT`, in which case Icache wins.
  - No request: `arb2Dmem_command=BUS_NONE`, addr/data 0.
- Accept response: the granted side sees `Dmem2arb_response` and the other side sees 0. A side that sees 0 must hold and re-present its request.
- Load accepted (`Dmem2arb_response!=0`): the owner entry [response] is written valid with the granted side. A store accept writes no entry, because stores do not return a tag.
- Completion (`Dmem2arb_tag!=0`):
  - Entry [tag] valid: the tag goes to that owner's `*_tag` and the other side gets 0. The entry is cleared.
  - Entry [tag] invalid: both `*_tag` outputs are 0 and `arb_tag_err` sets. The err flag clears only on reset.
- Same cycle, completion of tag T and accept with response T: the clear and the set both apply, and the set wins. The entry ends valid with the new owner.
- `outstanding_cnt` = popcount of valid entries, registered. It is updated by +1 per load accept and −1 per valid completion; both in the same cycle gives a net 0.
- `starve_cnt` (4 bits):
  - +1 each cycle Icache requests and is not accepted, saturating at `STARVE_LIMIT`.
  - Set to 0 on an Icache accept or when Icache is idle.
- Reset (`reset==0` at posedge):
  - Table invalidated, `starve_cnt=0`, `outstanding_cnt=0`, `arb_tag_err=0`.
  - While `reset==0`, all outputs are forced: commands BUS_NONE, responses and tags 0, addr/data 0.
  - Completions of stale pre-reset tags arriving after reset count as spurious and set `arb_tag_err`.

## Timing
- Request path: grant, address and accept response are all in the same cycle. The arbiter adds zero cycles.
- Completion routing: same cycle as `Dmem2arb_tag`, looked up in the table state as of that cycle. A load accepted in cycle N can be routed from cycle N+1 onward.
- Table, counters and err flag update at the posedge after the triggering event.
- The first Icache-priority grant occurs in the cycle where `starve_cnt` reads `STARVE_LIMIT`. That is `STARVE_LIMIT` blocked cycles after the first blocked request.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: the aging counter is present and Icache is promoted at `STARVE_LIMIT` as above.
- Not defined: the counter is removed, `STARVE_LIMIT` is unused and Dcache has fixed priority. Everything else is identical.

## Test plan
- Icache-only BUS_LOAD 0x100, mem response 3; later `Dmem2arb_tag=3` with data 0xAA → `arb2Icache_tag=3`, data 0xAA, `arb2Dcache_tag=0`, `outstanding_cnt` goes 0→1→0.
- Both request in the same cycle, mem response 5 → Dcache gets 5 and Icache gets 0. Tag 5 later goes to Dcache only.
- Guard on, `STARVE_LIMIT=4`, Dcache requests continuously, Icache continuously → Icache is granted on the 5th cycle, `starve_cnt` returns to 0, then Dcache wins again. Guard off → Icache is never granted.
- Dcache BUS_STORE addr 0x200 data 0x55, response 7 → mem sees store/0x200/0x55, no table entry, `outstanding_cnt` unchanged.
- Tag 9 returns while owned by Icache, same cycle as a Dcache load accepted with response 9 → Icache receives tag 9, entry 9 ends owned by Dcache, count unchanged.
- Two loads outstanding, `reset=0` for one cycle, then `Dmem2arb_tag=2` → all tags route to 0, `arb_tag_err=1`, `outstanding_cnt=0`.
